intersection_scheduler: RTL and testbench

//  Shares right-of-way at a multi-approach junction among C_N_APPROACH traffic-light

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/rr_picker.sv | 35 +++
 rtl/intersection_scheduler.sv | 165 ++++++++++++++++
 tb/tb_intersection_scheduler.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// +----------------------------------------------------------------------------+
// | traffic_pkg                                                                |
// | Shared state encodings, index-width helper and default junction intervals. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package traffic_pkg;

  typedef enum logic [1:0] {
    sClear  = 2'b00,
    sGrant  = 2'b01,
    sRevoke = 2'b10
  } state_t;

  localparam int C_DEF_N_APPROACH    = 4;
  localparam int C_DEF_INT_CLEAR     = 10;
  localparam int C_DEF_INT_MAX_GRANT = 250;
  localparam int C_DEF_TIMER_W       = 8;

  // Index width, never narrower than one bit.
  function automatic int log2c(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// +----------------------------------------------------------------------------+
// | rr_picker                                                                  |
// | Combinational round-robin pick: first set request at or after start.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_picker #(
  parameter int C_N_APPROACH = 4,
  parameter int C_IDX_W      = 2
) (
  input  logic [C_N_APPROACH-1:0] req,
  input  logic [C_IDX_W-1:0]      start,
  output logic                    valid,
  output logic [C_IDX_W-1:0]      idx
);

  logic [C_IDX_W-1:0] cand;

  // Scan from the farthest offset back to the start so the nearest hit wins.
  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = '0;
    for (int k = C_N_APPROACH - 1; k >= 0; k--) begin
      cand = C_IDX_W'((int'(start) + k) % C_N_APPROACH);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/intersection_scheduler.sv
// +----------------------------------------------------------------------------+
// | intersection_scheduler                                                     |
// | Round-robin right-of-way arbiter with all-red clearance and grant revoke.  |
// | Optional emergency preemption: `define INTERSECTION_PREEMPT_EN              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int C_N_APPROACH    = C_DEF_N_APPROACH,
  parameter int C_INT_CLEAR     = C_DEF_INT_CLEAR,
  parameter int C_INT_MAX_GRANT = C_DEF_INT_MAX_GRANT,
  parameter int C_TIMER_W       = C_DEF_TIMER_W,
  localparam int C_IDX_W        = log2c(C_N_APPROACH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    blink,
  input  logic [C_N_APPROACH-1:0] inReq,
`ifdef INTERSECTION_PREEMPT_EN
  input  logic                    inPreempt,
  input  logic [C_IDX_W-1:0]      inPreemptIdx,
`endif
  output logic [C_N_APPROACH-1:0] outGrant,
  output logic [C_IDX_W-1:0]      outGrantIdx,
  output logic                    outAllRed,
  output logic                    outRevoke
);

  localparam logic [C_IDX_W-1:0]      C_LAST_IDX  = C_IDX_W'(C_N_APPROACH - 1);
  localparam logic [C_N_APPROACH-1:0] C_ONE       = C_N_APPROACH'(1);
  localparam logic [C_TIMER_W-1:0]    C_TIMER_SAT = '1;
  localparam logic [C_TIMER_W-1:0]    C_CLEAR_T   = C_TIMER_W'(C_INT_CLEAR);
  localparam logic [C_TIMER_W-1:0]    C_MAX_T     = C_TIMER_W'(C_INT_MAX_GRANT);

  state_t               state;
  logic [C_TIMER_W-1:0] timer;
  logic                 blink_q;
  logic                 blink_rise;
  logic [C_IDX_W-1:0]   rr_base;
  logic [C_IDX_W-1:0]   rr_next;
  logic                 pick_valid;
  logic [C_IDX_W-1:0]   pick_idx;
  logic                 clear_done;
  logic                 others_wait;
  logic                 release_now;
  logic                 revoke_now;

  assign blink_rise  = blink & ~blink_q;
  assign clear_done  = (timer >= C_CLEAR_T);
  assign others_wait = |(inReq & ~outGrant);
  assign rr_next     = (rr_base == C_LAST_IDX) ? '0 : rr_base + 1'b1;

`ifdef INTERSECTION_PREEMPT_EN
  // Preempt grants must not disturb the round-robin rotation.
  logic [C_IDX_W-1:0] rr_ptr;
  logic               preempt_grant;

  assign rr_base     = rr_ptr;
  assign release_now = preempt_grant ? ~inPreempt : ~inReq[outGrantIdx];
  assign revoke_now  = ~preempt_grant &
                       (((timer >= C_MAX_T) & others_wait) |
                        (inPreempt & (outGrantIdx != inPreemptIdx)));
`else
  assign rr_base     = outGrantIdx;
  assign release_now = ~inReq[outGrantIdx];
  assign revoke_now  = (timer >= C_MAX_T) & others_wait;
`endif

  rr_picker #(
    .C_N_APPROACH (C_N_APPROACH),
    .C_IDX_W      (C_IDX_W)
  ) u_rr_picker (
    .req   (inReq),
    .start (rr_next),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q     <= 1'b0;
      state       <= sClear;
      timer       <= '0;
      outGrant    <= '0;
      outGrantIdx <= C_LAST_IDX;
      outAllRed   <= 1'b1;
      outRevoke   <= 1'b0;
`ifdef INTERSECTION_PREEMPT_EN
      rr_ptr        <= C_LAST_IDX;
      preempt_grant <= 1'b0;
`endif
    end else begin
      blink_q <= blink;
      // Later timer assignments on a state change override this increment.
      if (blink_rise && (timer != C_TIMER_SAT)) begin
        timer <= timer + 1'b1;
      end
      case (state)
        sClear: begin
`ifdef INTERSECTION_PREEMPT_EN
          if (clear_done && inPreempt) begin
            state         <= sGrant;
            timer         <= '0;
            outGrant      <= C_ONE << inPreemptIdx;
            outGrantIdx   <= inPreemptIdx;
            outAllRed     <= 1'b0;
            preempt_grant <= 1'b1;
          end else
`endif
          if (clear_done && pick_valid) begin
            state       <= sGrant;
            timer       <= '0;
            outGrant    <= C_ONE << pick_idx;
            outGrantIdx <= pick_idx;
            outAllRed   <= 1'b0;
`ifdef INTERSECTION_PREEMPT_EN
            rr_ptr        <= pick_idx;
            preempt_grant <= 1'b0;
`endif
          end
        end
        sGrant: begin
          if (release_now) begin
            state     <= sClear;
            timer     <= '0;
            outGrant  <= '0;
            outAllRed <= 1'b1;
          end else if (revoke_now) begin
            state     <= sRevoke;
            timer     <= '0;
            outRevoke <= 1'b1;
          end
        end
        sRevoke: begin
          // The holder keeps the grant until it finishes yellow and drops its request.
          if (release_now) begin
            state     <= sClear;
            timer     <= '0;
            outGrant  <= '0;
            outAllRed <= 1'b1;
            outRevoke <= 1'b0;
          end
        end
        default: begin
          state       <= sClear;
          timer       <= '0;
          outGrant    <= '0;
          outGrantIdx <= C_LAST_IDX;
          outAllRed   <= 1'b1;
          outRevoke   <= 1'b0;
`ifdef INTERSECTION_PREEMPT_EN
          rr_ptr        <= C_LAST_IDX;
          preempt_grant <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_intersection_scheduler                                                  |
// | Self-checking bench with an event-level junction model and random traffic. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_intersection_scheduler;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int CLR  = 3;
  localparam int MAXG = 10;
  localparam int TW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          blink;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] gidx;
  logic          all_red;
  logic          revoke;
`ifdef INTERSECTION_PREEMPT_EN
  logic          pre;
  logic [IW-1:0] pre_idx;
`endif

  intersection_scheduler #(
    .C_N_APPROACH    (N),
    .C_INT_CLEAR     (CLR),
    .C_INT_MAX_GRANT (MAXG),
    .C_TIMER_W       (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .blink        (blink),
    .inReq        (req),
`ifdef INTERSECTION_PREEMPT_EN
    .inPreempt    (pre),
    .inPreemptIdx (pre_idx),
`endif
    .outGrant     (grant),
    .outGrantIdx  (gidx),
    .outAllRed    (all_red),
    .outRevoke    (revoke)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Junction model: who holds the right-of-way, who was served last,
  // blinks counted in the current phase, and whether a revoke is pending.
  int m_holder;
  int m_last;
  int m_phase;
  bit m_revoked;
  bit m_bprev;

  task automatic model_reset();
    m_holder  = -1;
    m_last    = N - 1;
    m_phase   = 0;
    m_revoked = 1'b0;
    m_bprev   = 1'b0;
  endtask

  task automatic model_step();
    bit           rise;
    logic [N-1:0] mine;
    rise    = blink && !m_bprev;
    m_bprev = blink;
    if (m_holder < 0) begin
      if (m_phase >= CLR && req != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (req[IW'((m_last + k) % N)]) begin
            m_holder = (m_last + k) % N;
            break;
          end
        end
        m_last  = m_holder;
        m_phase = 0;
      end else if (rise) begin
        m_phase = (m_phase < 255) ? m_phase + 1 : 255;
      end
    end else begin
      mine = N'(1 << m_holder);
      if ((req & mine) == '0) begin
        m_holder  = -1;
        m_revoked = 1'b0;
        m_phase   = 0;
      end else if (!m_revoked && m_phase >= MAXG && (req & ~mine) != '0) begin
        m_revoked = 1'b1;
        m_phase   = 0;
      end else if (rise) begin
        m_phase = (m_phase < 255) ? m_phase + 1 : 255;
      end
    end
  endtask

  function automatic logic [7:0] m_vec();
    logic [N-1:0] g;
    g = (m_holder >= 0) ? N'(1 << m_holder) : '0;
    return {g, IW'(m_last), (m_holder < 0), m_revoked};
  endfunction

  // One clock: blink every 4th cycle, model advances with the same inputs the DUT sees.
  task automatic tick();
    cyc++;
    blink = (cyc % 4 == 0);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    blink = 1'b0;
`ifdef INTERSECTION_PREEMPT_EN
    pre     = 1'b0;
    pre_idx = '0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({grant, gidx, all_red, revoke} !== {4'b0000, 2'd3, 1'b1, 1'b0})
      $display("FAIL reset_state got=%b exp=%b", {grant, gidx, all_red, revoke}, 8'b0000_11_1_0);
    else n_pass++;
    for (int c = 1; c <= 11; c++) begin
      tick();
      n_checks++;
      if (grant !== 4'b0000 || all_red !== 1'b1)
        $display("FAIL idle_all_red cyc=%0d grant=%b all_red=%b exp 0000/1", cyc, grant, all_red);
      else n_pass++;
    end
    req = 4'b0001;
    tick();
    n_checks++;
    if (grant !== 4'b0000)
      $display("FAIL third_blink_edge grant=%b exp=0000", grant);
    else n_pass++;
    tick();
    n_checks++;
    if (grant !== 4'b0001 || gidx !== 2'd0 || all_red !== 1'b0)
      $display("FAIL first_grant grant=%b idx=%0d all_red=%b exp 0001/0/0", grant, gidx, all_red);
    else n_pass++;
  endtask

  task automatic test_rotation();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int hb;
    int clr_blinks;
    int prev_h;
    logic [N-1:0] prev_grant;
    logic prev_red;
    do_reset();
    req = 4'b1111;
    hb = 0;
    clr_blinks = 0;
    prev_grant = grant;
    for (int c = 0; c < 400 && order.size() < 5; c++) begin
      if (m_holder >= 0) begin
        if (hb >= 2) req[IW'(m_holder)] = 1'b0;
      end else begin
        req = 4'b1111;
      end
      prev_h   = m_holder;
      prev_red = all_red;
      tick();
      if (m_holder != prev_h) hb = 0;
      else if (blink && m_holder >= 0) hb++;
      if (prev_red && blink) clr_blinks++;
      n_checks++;
      if ({grant, gidx, all_red, revoke} !== m_vec())
        $display("FAIL rotation_cycle cyc=%0d got=%b exp=%b", cyc, {grant, gidx, all_red, revoke}, m_vec());
      else n_pass++;
      if (grant != '0 && prev_grant == '0) begin
        order.push_back(int'(gidx));
        n_checks++;
        if (clr_blinks != 3)
          $display("FAIL clearance_blinks got=%0d exp=3", clr_blinks);
        else n_pass++;
        clr_blinks = 0;
      end
      prev_grant = grant;
    end
    n_checks++;
    if (order.size() != 5)
      $display("FAIL rotation_count got=%0d exp=5", order.size());
    else n_pass++;
    for (int i = 0; i < order.size() && i < 5; i++) begin
      n_checks++;
      if (order[i] != exp_order[i])
        $display("FAIL rotation_order pos=%0d got=%0d exp=%0d", i, order[i], exp_order[i]);
      else n_pass++;
    end
  endtask

  task automatic test_revoke();
    int  blinks;
    int  b2;
    bit  seen;
    bit  held_before;
    do_reset();
    req = 4'b0101;
    blinks = 0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      held_before = (grant == 4'b0001);
      tick();
      n_checks++;
      if ({grant, gidx, all_red, revoke} !== m_vec())
        $display("FAIL revoke_cycle cyc=%0d got=%b exp=%b", cyc, {grant, gidx, all_red, revoke}, m_vec());
      else n_pass++;
      if (held_before && blink) blinks++;
      if (revoke) seen = 1'b1;
    end
    n_checks++;
    if (!seen || blinks != 10 || grant !== 4'b0001)
      $display("FAIL revoke_timing seen=%0d blinks=%0d grant=%b exp 1/10/0001", seen, blinks, grant);
    else n_pass++;
    b2 = 0;
    for (int c = 0; c < 40 && b2 < 2; c++) begin
      tick();
      if (blink) b2++;
      n_checks++;
      if (revoke !== 1'b1 || grant !== 4'b0001)
        $display("FAIL revoke_hold revoke=%b grant=%b exp 1/0001", revoke, grant);
      else n_pass++;
    end
    req[0] = 1'b0;
    tick();
    n_checks++;
    if ({grant, all_red, revoke} !== {4'b0000, 1'b1, 1'b0})
      $display("FAIL revoke_release got=%b exp=%b", {grant, all_red, revoke}, 6'b0000_1_0);
    else n_pass++;
    for (int c = 0; c < 60 && grant == '0; c++) begin
      tick();
      n_checks++;
      if ({grant, gidx, all_red, revoke} !== m_vec())
        $display("FAIL revoke_clear_cycle cyc=%0d got=%b exp=%b", cyc, {grant, gidx, all_red, revoke}, m_vec());
      else n_pass++;
    end
    n_checks++;
    if (grant !== 4'b0100 || gidx !== 2'd2)
      $display("FAIL grant_after_revoke grant=%b idx=%0d exp 0100/2", grant, gidx);
    else n_pass++;
  endtask

  task automatic test_no_revoke();
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 120; c++) begin
      tick();
      n_checks++;
      if ({grant, gidx, all_red, revoke} !== m_vec())
        $display("FAIL lone_holder_cycle cyc=%0d got=%b exp=%b", cyc, {grant, gidx, all_red, revoke}, m_vec());
      else n_pass++;
    end
    n_checks++;
    if (grant !== 4'b0010 || revoke !== 1'b0)
      $display("FAIL lone_holder grant=%b revoke=%b exp 0010/0", grant, revoke);
    else n_pass++;
  endtask

  task automatic test_clear_pulse();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      req = (c == 1 || c == 2) ? 4'b0010 : 4'b0000;
      tick();
      n_checks++;
      if (grant !== 4'b0000 || !$onehot0(grant) || all_red !== ~|grant)
        $display("FAIL clear_pulse cyc=%0d grant=%b all_red=%b exp 0000/1", cyc, grant, all_red);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    bit got;
    int first;
    do_reset();
    req = 4'b0001;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      got = (grant != '0);
    end
    n_checks++;
    if (!got) $display("FAIL async_setup_grant grant=%b exp=0001", grant);
    else n_pass++;
    #2 rst = 1'b1;
    blink = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0000 || all_red !== 1'b1)
      $display("FAIL async_reset_drop grant=%b all_red=%b exp 0000/1", grant, all_red);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
    first = -1;
    for (int c = 0; c < 40 && first < 0; c++) begin
      tick();
      if (grant != '0) first = cyc;
    end
    n_checks++;
    if (first != 13)
      $display("FAIL regrant_after_reset cyc=%0d exp=13", first);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      for (int b = 0; b < N; b++) begin
        if (m_holder == b) begin
          if ($urandom_range(0, 49) == 0) req[IW'(b)] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          req[IW'(b)] = ~req[IW'(b)];
        end
      end
      tick();
      n_checks++;
      if ({grant, gidx, all_red, revoke} !== m_vec() || !$onehot0(grant) || all_red !== ~|grant)
        $display("FAIL random_cycle cyc=%0d got=%b exp=%b", cyc, {grant, gidx, all_red, revoke}, m_vec());
      else n_pass++;
    end
  endtask

`ifdef INTERSECTION_PREEMPT_EN
  task automatic test_preempt();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 40 && grant == '0; c++) tick();
    pre_idx = 2'd3;
    pre = 1'b1;
    tick();
    n_checks++;
    if (revoke !== 1'b1 || grant !== 4'b0001)
      $display("FAIL preempt_revoke revoke=%b grant=%b exp 1/0001", revoke, grant);
    else n_pass++;
    req = 4'b0000;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || all_red !== 1'b1)
      $display("FAIL preempt_release grant=%b exp=0000", grant);
    else n_pass++;
    for (int c = 0; c < 40 && grant == '0; c++) tick();
    n_checks++;
    if (grant !== 4'b1000 || gidx !== 2'd3)
      $display("FAIL preempt_grant grant=%b idx=%0d exp 1000/3", grant, gidx);
    else n_pass++;
    repeat (8) tick();
    n_checks++;
    if (grant !== 4'b1000 || revoke !== 1'b0)
      $display("FAIL preempt_hold grant=%b revoke=%b exp 1000/0", grant, revoke);
    else n_pass++;
    pre = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b0000)
      $display("FAIL preempt_drop grant=%b exp=0000", grant);
    else n_pass++;
    req = 4'b1111;
    for (int c = 0; c < 40 && grant == '0; c++) tick();
    n_checks++;
    if (grant !== 4'b0010)
      $display("FAIL preempt_rotation grant=%b exp=0010", grant);
    else n_pass++;
  endtask
`endif

  initial begin
    rst   = 1'b1;
    req   = '0;
    blink = 1'b0;
`ifdef INTERSECTION_PREEMPT_EN
    pre     = 1'b0;
    pre_idx = '0;
`endif
    model_reset();
    test_reset();
    test_rotation();
    test_revoke();
    test_no_revoke();
    test_clear_pulse();
    test_async_reset();
    test_random();
`ifdef INTERSECTION_PREEMPT_EN
    test_preempt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
